// File: rtl/uart_ecc_sequencer.sv
// UART loopback sequencer: receiver -> Hamming(7,4) checker -> transmitter.
// Holds each byte through the checker latency, applies the correction, then launches a frame.
module uart_ecc_sequencer #(
   parameter int         ECC_LAT  = 2,
   parameter logic [7:0] ERR_BYTE = 8'hFF,
   parameter int         CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_ready,
   input  logic [7:0]       rx_data,
   output logic [6:0]       ecc_code,
   input  logic             ecc_err,
   input  logic [2:0]       ecc_loc,
   output logic             tx_start,
   output logic [7:0]       tx_data,
   input  logic             tx_busy,
   input  logic             clr,
   output logic             busy,
   output logic             overrun,
   output logic [CNT_W-1:0] err_count
);

   localparam int LW = (ECC_LAT < 2) ? 1 : $clog2(ECC_LAT + 1);
   localparam logic [LW-1:0] LAT_LD = LW'(ECC_LAT);
   localparam logic [LW-1:0] LAT_ONE = LW'(1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CHECK   = 3'd1;
   localparam logic [2:0] S_CORRECT = 3'd2;
   localparam logic [2:0] S_SEND    = 3'd3;
   localparam logic [2:0] S_WAIT    = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [6:0]       hold_q, hold_d;
   logic [LW-1:0]    cnt_q, cnt_d;
   logic [7:0]       txd_q, txd_d;
   logic             seen_q, seen_d;
   logic             first_q, first_d;
   logic             ovr_q, ovr_d;
   logic [CNT_W-1:0] errc_q, errc_d;

   logic wait_done;
   logic accept;
   logic drop;
   logic fix;
   logic unused_rx7;

   assign unused_rx7 = rx_data[7];

   // A frame ends on busy falling, or if busy never rose by the 2nd cycle after start.
   assign wait_done = (state_q == S_WAIT) & ~tx_busy & (seen_q | ~first_q);
   assign accept    = rx_ready & ((state_q == S_IDLE) | wait_done);
   assign drop      = rx_ready & ~accept;
   assign fix       = ecc_err & (ecc_loc != 3'd7);

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      txd_d   = txd_q;
      seen_d  = seen_q;
      first_d = first_q;
      unique case (1'b1)
         (state_q == S_CHECK): begin
            cnt_d = cnt_q - LAT_ONE;
            if (cnt_q == LAT_ONE) begin
               state_d = S_CORRECT;
            end
         end
         (state_q == S_CORRECT): begin
            if (!ecc_err) begin
               txd_d = {1'b0, hold_q};
            end else if (fix) begin
               txd_d = {1'b0, hold_q ^ (7'd1 << ecc_loc)};
            end else begin
               txd_d = ERR_BYTE;
            end
            state_d = S_SEND;
         end
         (state_q == S_SEND): begin
            if (!tx_busy) begin
               state_d = S_WAIT;
               first_d = 1'b1;
               seen_d  = 1'b0;
            end
         end
         (state_q == S_WAIT): begin
            first_d = 1'b0;
            if (tx_busy) begin
               seen_d = 1'b1;
            end
            if (wait_done) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase
      if (accept) begin
         hold_d  = rx_data[6:0];
         cnt_d   = LAT_LD;
         state_d = S_CHECK;
      end
   end

   always_comb begin
      errc_d = errc_q;
      ovr_d  = ovr_q;
      if (clr) begin
         errc_d = '0;
         ovr_d  = 1'b0;
      end else begin
         if ((state_q == S_CORRECT) && fix && !(&errc_q)) begin
            errc_d = errc_q + 1'b1;
         end
         if (drop) begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         hold_q  <= '0;
         cnt_q   <= '0;
         txd_q   <= '0;
         seen_q  <= 1'b0;
         first_q <= 1'b0;
         ovr_q   <= 1'b0;
         errc_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         txd_q   <= txd_d;
         seen_q  <= seen_d;
         first_q <= first_d;
         ovr_q   <= ovr_d;
         errc_q  <= errc_d;
      end
   end

   assign ecc_code  = hold_q;
   assign tx_start  = (state_q == S_SEND) & ~tx_busy;
   assign tx_data   = txd_q;
   assign busy      = (state_q != S_IDLE);
   assign overrun   = ovr_q;
   assign err_count = errc_q;

endmodule
